// File: rtl/pkt_fifo_ctrl.sv
// pkt_fifo_ctrl: packet commit/rollback controller in front of a fifo_sync with write-pointer rewind
module pkt_fifo_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int W_DATA = 19,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W_DATA-1:0]     in_data,
  input  logic                  in_last,
  input  logic                  in_drop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W_DATA-1:0]     out_data,
  output logic                  out_last,
  output logic                  fifo_wen,
  output logic [W_DATA:0]       fifo_wdata,
  input  logic                  fifo_full,
  output logic                  fifo_wrst,
  output logic [ADDR_WIDTH:0]   fifo_rst_wptr,
  output logic                  fifo_rrst,
  output logic [ADDR_WIDTH:0]   fifo_rst_rptr,
  input  logic [ADDR_WIDTH:0]   fifo_wptr,
  output logic                  fifo_ren,
  input  logic [W_DATA:0]       fifo_rdata,
  input  logic [ADDR_WIDTH:0]   fifo_rptr,
  output logic [ADDR_WIDTH:0]   pkts_buffered,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  oversize_cnt
);
  localparam int PW = ADDR_WIDTH + 1;
  typedef enum logic {S_PKT, S_DISCARD} state_t;
  state_t state, state_nx;
  logic [PW-1:0] commit_ptr;
  logic [W_DATA:0] buf_mem [2];
  logic [W_DATA:0] head;
  logic [1:0] buf_cnt;
  logic buf_wi, buf_ri, inflight;
  logic accept, oversize, commit, drop, sink_last, pop, last_pop;
  assign oversize = fifo_full && fifo_rptr == commit_ptr && fifo_wptr != commit_ptr;
  assign accept = in_valid && in_ready;
  assign commit = state == S_PKT && accept && in_last && !in_drop;
  assign drop = state == S_PKT && accept && in_last && in_drop;
  assign sink_last = state == S_DISCARD && accept && in_last;
  assign fifo_wdata = {in_last, in_data};
  assign fifo_rst_wptr = commit_ptr;
  assign fifo_rrst = 1'b0;
  assign fifo_rst_rptr = '0;
  assign head = buf_mem[buf_ri];
  assign out_valid = reset && buf_cnt != 2'd0;
  assign out_data = head[W_DATA-1:0];
  assign out_last = head[W_DATA];
  assign pop = out_valid && out_ready;
  assign last_pop = pop && out_last;
  assign fifo_ren = reset && fifo_rptr != commit_ptr && ({1'b0, buf_cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
  // write FSM state register
  always_ff @(posedge clk)
    state <= !reset ? S_PKT : state_nx;
  // an oversize packet switches to sinking; the sunk packet's last beat returns to normal
  always_comb begin
    state_nx = state == S_PKT ? (oversize ? S_DISCARD : S_PKT) : (sink_last ? S_PKT : S_DISCARD);
  end
  // write-side strobes; a drop beat is consumed but rewinds instead of writing
  always_comb begin
    in_ready = reset && (state == S_DISCARD || !fifo_full);
    fifo_wen = reset && state == S_PKT && in_valid && !fifo_full && !(in_last && in_drop);
    fifo_wrst = reset && state == S_PKT && (oversize || (in_valid && !fifo_full && in_last && in_drop));
  end
  // commit pointer, buffered-packet count and saturating event counters
  always_ff @(posedge clk)
    if (!reset) begin
      commit_ptr <= '0;
      pkts_buffered <= '0;
      drop_cnt <= '0;
      oversize_cnt <= '0;
    end else begin
      if (commit) commit_ptr <= fifo_wptr + 1'b1;
      pkts_buffered <= pkts_buffered + PW'(commit) - PW'(last_pop);
      if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
      if (sink_last && !(&oversize_cnt)) oversize_cnt <= oversize_cnt + 1'b1;
    end
  // two-entry output buffer fed by the one-cycle-latency FIFO read
  always_ff @(posedge clk)
    if (!reset) begin
      buf_cnt <= 2'd0;
      buf_wi <= 1'b0;
      buf_ri <= 1'b0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_ren;
      if (inflight) begin
        buf_mem[buf_wi] <= fifo_rdata;
        buf_wi <= !buf_wi;
      end
      if (pop) buf_ri <= !buf_ri;
      buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
    end
endmodule

// File: doc/pkt_fifo_ctrl.md
Name: pkt_fifo_ctrl

Overview:
- Packet-level commit/rollback controller sequencing one external fifo_sync instance (CAN_RESET_POINTERS=1, W_EL=W_DATA+1) in the packet filter datapath.
- Writes ingress words into the FIFO and commits each packet on its last beat. A packet flagged for drop is rolled back by rewinding the FIFO write pointer.
- Exposes only committed packets to the downstream reader through a 2-entry output buffer.
- Detects packets larger than the FIFO and discards them to avoid deadlock.

Parameters:
- ADDR_WIDTH, 11, FIFO address width; depth = 2**ADDR_WIDTH; must match the fifo_sync instance.
- W_DATA, 19, payload width. The FIFO word is {last, data}, W_DATA+1 bits.
- CNT_WIDTH, 16, width of the saturating drop/oversize counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset. The integrator drives the fifo_sync reset with !reset.
- in_valid  in  1  ingress word valid.
- in_ready  out  1  ingress ready.
- in_data  in  W_DATA  ingress payload.
- in_last  in  1  last word of the packet.
- in_drop  in  1  drop verdict; sampled only on a last beat.
- out_valid  out  1  egress word valid.
- out_ready  in  1  egress ready.
- out_data  out  W_DATA  egress payload.
- out_last  out  1  egress last word.
- fifo_wen  out  1  FIFO write enable.
- fifo_wdata  out  W_DATA+1  {in_last, in_data}.
- fifo_full  in  1  FIFO full.
- fifo_wrst  out  1  FIFO write-pointer reset.
- fifo_rst_wptr  out  ADDR_WIDTH+1  rewind target; always equals commit_ptr.
- fifo_rrst  out  1  tied 0.
- fifo_rst_rptr  out  ADDR_WIDTH+1  tied 0.
- fifo_wptr  in  ADDR_WIDTH+1  FIFO write pointer.
- fifo_ren  out  1  FIFO read enable.
- fifo_rdata  in  W_DATA+1  FIFO read data; 1-cycle latency.
- fifo_rptr  in  ADDR_WIDTH+1  FIFO read pointer.
- pkts_buffered  out  ADDR_WIDTH+1  committed packets whose last word has not yet left out_*.
- drop_cnt  out  CNT_WIDTH  packets dropped by verdict; saturating.
- oversize_cnt  out  CNT_WIDTH  packets discarded as oversize; saturating.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=S_PKT, commit_ptr=0.
  - Output buffer empty, inflight=0, all counters 0.
  - While reset is low: in_ready=0, out_valid=0, fifo_wen/fifo_ren/fifo_wrst=0.
  - Reset mid-packet loses the partial packet and all buffered data.
- Write FSM, state S_PKT:
  - in_ready = !fifo_full.
  - Accepted beat, not last: fifo_wen=1.
  - Accepted beat with in_last=1, in_drop=0:
    - fifo_wen=1; commit_ptr <= fifo_wptr+1 (mod 2**(ADDR_WIDTH+1)).
    - pkts_buffered increments.
  - Accepted beat with in_last=1, in_drop=1:
    - fifo_wen=0, fifo_wrst=1 (rst_wptr=commit_ptr); the beat is consumed and not written.
    - drop_cnt increments; the next cycle sees fifo_wptr==commit_ptr.
  - Oversize: if fifo_full=1, fifo_rptr==commit_ptr and fifo_wptr!=commit_ptr (the FIFO holds only the uncommitted packet):
    - Assert fifo_wrst=1 that cycle, with no accept.
    - Go to S_DISCARD.
- Write FSM, state S_DISCARD:
  - in_ready=1, fifo_wen=0; all beats are sunk.
  - On an accepted in_last beat (in_drop ignored): oversize_cnt increments, go to S_PKT.
- Counters saturate at all-ones.
- Read side:
  - Words are readable only while fifo_rptr != commit_ptr. fifo_empty is not used; its reset value is unreliable and it sees uncommitted data.
  - fifo_ren=1 when fifo_rptr != commit_ptr and buf_cnt + inflight - pop < 2, where pop = out_valid && out_ready.
  - inflight <= fifo_ren. When inflight=1, fifo_rdata is pushed into the buffer the following cycle.
  - Buffer is a 2-entry FIFO. out_valid = buf_cnt>0; out_data/out_last come from the head.
  - Sustains 1 word/clk when out_ready is held high.
  - The buffer never overflows.
- pkts_buffered:
  - Decrements on pop with out_last=1.
  - Commit and last-pop in the same cycle leave it unchanged.
- Simultaneous events:
  - Commit and read in one cycle: independent.
  - Drop rewind never moves fifo_wptr below commit_ptr, so committed data is unaffected.
  - A commit makes the new words eligible for read the following cycle.

Test Plan:
- Reset, then a 4-word packet (data 1..4, last on 4, drop=0), out_ready=1 → out_data 1,2,3,4 with out_last only on 4; pkts_buffered 0→1→0; drop_cnt=0.
- A 3-word packet with drop=1 on the last beat, then a 2-word packet A,B committed → only A,B emerge; drop_cnt=1; fifo_wptr returns to its pre-drop value one cycle after the drop beat.
- A 5-word packet streamed while out_ready=0 → out_valid stays 0 until the last beat commits, then goes high and holds word 1 stable.
- ADDR_WIDTH=2 (depth 4), out_ready=1, 7-word packet → after 4 writes, S_DISCARD; words 5-7 sunk with in_ready=1; oversize_cnt=1; a following 2-word packet is delivered intact.
- Back-to-back committed packets with random out_ready (50%) → every word delivered in order, no duplicates or losses, pkts_buffered never negative.
- Assert reset low mid-packet after 2 of 4 words, then release → out_valid=0, pkts_buffered=0, and the next packet is delivered correctly.
